// File: rtl/color_rect_extract_pkg.sv
// Shared constants, item entry layout and coordinate saturation for the rectangle extractor.
package color_rect_extract_pkg;

    localparam int unsigned OV5640_X       = 640;
    localparam int unsigned OV5640_Y       = 480;
    localparam int unsigned RECT_NUMMAX    = 4;
    localparam int unsigned POSITION_WIDTH = 12;

    localparam logic [16*RECT_NUMMAX-1:0] DEFAULT_CLASS_COLORS =
        {16'h8410, 16'hF800, 16'h001F, 16'h07E0};

    typedef struct packed {
        logic [7:0] x0;
        logic [7:0] y0;
        logic [7:0] x1;
        logic [7:0] y1;
    } item_t;

    function automatic logic [7:0] sat8(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/color_rect_extract_rect_accum.sv
// Per-class bounding-box accumulator; publishes the packed entry at frame end and restarts.
module rect_accum
    import color_rect_extract_pkg::*;
#(
    parameter int unsigned P_W         = POSITION_WIDTH,
    parameter int unsigned COORD_SHIFT = 2,
    parameter int unsigned MIN_PIX     = 16
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    input  logic           i_clear,
    input  logic           i_hit,
    input  logic [P_W-1:0] i_x,
    input  logic [P_W-1:0] i_y,
    input  logic           i_publish,
    output logic [31:0]    o_entry
);

    logic [P_W-1:0] r_xmin, r_ymin, r_xmax, r_ymax;
    logic [15:0]    r_cnt;
    logic [31:0]    r_entry;

    logic [P_W-1:0] w_xmin, w_ymin, w_xmax, w_ymax;
    logic [15:0]    w_cnt;
    item_t          w_entry;

    // Merged state including the current hit, so the final pixel lands in the published entry.
    always_comb begin
        w_xmin = r_xmin;
        w_ymin = r_ymin;
        w_xmax = r_xmax;
        w_ymax = r_ymax;
        w_cnt  = r_cnt;
        if (i_hit) begin
            if (r_cnt == 16'd0) begin
                w_xmin = i_x;
                w_ymin = i_y;
                w_xmax = i_x;
                w_ymax = i_y;
            end else begin
                if (i_x < r_xmin) w_xmin = i_x;
                if (i_y < r_ymin) w_ymin = i_y;
                if (i_x > r_xmax) w_xmax = i_x;
                if (i_y > r_ymax) w_ymax = i_y;
            end
            if (r_cnt != 16'hFFFF) w_cnt = r_cnt + 16'd1;
        end
    end

    always_comb begin
        w_entry = '0;
        if (w_cnt >= 16'(MIN_PIX)) begin
            w_entry.x0 = sat8(32'(w_xmin) >> COORD_SHIFT);
            w_entry.y0 = sat8(32'(w_ymin) >> COORD_SHIFT);
            w_entry.x1 = sat8(32'(w_xmax) >> COORD_SHIFT);
            w_entry.y1 = sat8(32'(w_ymax) >> COORD_SHIFT);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_xmin  <= '0;
            r_ymin  <= '0;
            r_xmax  <= '0;
            r_ymax  <= '0;
            r_cnt   <= '0;
            r_entry <= '0;
        end else if (i_publish || i_clear) begin
            if (i_publish) r_entry <= w_entry;
            r_xmin <= '0;
            r_ymin <= '0;
            r_xmax <= '0;
            r_ymax <= '0;
            r_cnt  <= '0;
        end else begin
            r_xmin <= w_xmin;
            r_ymin <= w_ymin;
            r_xmax <= w_xmax;
            r_ymax <= w_ymax;
            r_cnt  <= w_cnt;
        end
    end

    assign o_entry = r_entry;

endmodule

// File: rtl/color_rect_extract.sv
// Per-class bounding rectangles over each camera frame of the recoloured pixel stream.
module color_rect_extract
    import color_rect_extract_pkg::*;
#(
    parameter int unsigned              P_W          = POSITION_WIDTH,
    parameter int unsigned              FRAME_X      = OV5640_X,
    parameter int unsigned              FRAME_Y      = OV5640_Y,
    parameter int unsigned              RECT_NUM     = RECT_NUMMAX,
    parameter logic [16*RECT_NUM-1:0]   CLASS_COLORS = DEFAULT_CLASS_COLORS,
    parameter int unsigned              COORD_SHIFT  = 2,
    parameter int unsigned              MIN_PIX      = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  i_post_camvs,
    input  logic                  i_valid,
    input  logic [15:0]           i_data,
    output logic [RECT_NUM*32-1:0] o_item,
    output logic                  o_frame_done
);

    logic                r_camvs;
    logic [P_W-1:0]      r_cnt_x, r_cnt_y;
    logic [RECT_NUM-1:0] r_s1_match;
    logic [P_W-1:0]      r_s1_x, r_s1_y;
    logic                r_s1_last;
    logic                r_frame_done;

    logic                w_vs_rise;
    logic                w_pix;
    logic                w_x_end, w_y_end;
    logic [RECT_NUM-1:0] w_match;

    assign w_vs_rise = i_post_camvs & ~r_camvs;
    // A strobe coinciding with the frame-sync edge belongs to neither frame.
    assign w_pix     = i_valid & ~w_vs_rise;
    assign w_x_end   = (r_cnt_x == P_W'(FRAME_X - 1));
    assign w_y_end   = (r_cnt_y == P_W'(FRAME_Y - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_camvs <= 1'b0;
            r_cnt_x <= '0;
            r_cnt_y <= '0;
        end else begin
            r_camvs <= i_post_camvs;
            if (w_vs_rise) begin
                r_cnt_x <= '0;
                r_cnt_y <= '0;
            end else if (i_valid) begin
                if (w_x_end) begin
                    r_cnt_x <= '0;
                    r_cnt_y <= w_y_end ? '0 : r_cnt_y + 1'b1;
                end else begin
                    r_cnt_x <= r_cnt_x + 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < RECT_NUM; k++) begin : g_match
        assign w_match[k] = w_pix && (i_data == CLASS_COLORS[16*k +: 16]);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_s1_match   <= '0;
            r_s1_x       <= '0;
            r_s1_y       <= '0;
            r_s1_last    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_s1_match   <= w_match;
            r_s1_x       <= r_cnt_x;
            r_s1_y       <= r_cnt_y;
            r_s1_last    <= w_pix & w_x_end & w_y_end;
            r_frame_done <= r_s1_last;
        end
    end

    // Publish takes the pre-clear state, so a sync edge racing the last pixel cannot lose it.
    for (genvar k = 0; k < RECT_NUM; k++) begin : g_accum
        rect_accum #(
            .P_W        (P_W),
            .COORD_SHIFT(COORD_SHIFT),
            .MIN_PIX    (MIN_PIX)
        ) u_rect_accum (
            .sys_clk  (sys_clk),
            .sys_rst_n(sys_rst_n),
            .i_clear  (w_vs_rise),
            .i_hit    (r_s1_match[k]),
            .i_x      (r_s1_x),
            .i_y      (r_s1_y),
            .i_publish(r_s1_last),
            .o_entry  (o_item[32*k +: 32])
        );
    end

    assign o_frame_done = r_frame_done;

endmodule
